// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - register file with RAW scoreboard and sequential clear; REG_FILE_BYPASS_EN enables write-through forwarding
module reg_file_sb #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              WR_EN,
    input  logic [ADDR_W-1:0] WR_ADDR,
    input  logic [DATA_W-1:0] WR_DATA,
    input  logic              ISSUE_EN,
    input  logic [ADDR_W-1:0] ISSUE_ADDR,
    input  logic [ADDR_W-1:0] RD1_ADDR,
    input  logic [ADDR_W-1:0] RD2_ADDR,
    output logic [DATA_W-1:0] RD1_DATA,
    output logic [DATA_W-1:0] RD2_DATA,
    output logic              RD1_BUSY,
    output logic              RD2_BUSY,
    output logic              READY
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
    logic                ready_q, ready_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];
    logic [DEPTH-1:0]    busy_q, busy_d;

    logic wr_ok;
    logic iss_ok;

    assign wr_ok  = (state_q == ST_RUN) && WR_EN && (WR_ADDR != '0);
    assign iss_ok = (state_q == ST_RUN) && ISSUE_EN && (ISSUE_ADDR != '0);

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        ready_d   = ready_q;
        mem_d     = mem_q;
        busy_d    = busy_q;
        if (RESET) begin
            state_d   = ST_CLEAR;
            clr_idx_d = '0;
            busy_d    = '0;
            ready_d   = 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    mem_d[clr_idx_q] = '0;
                    clr_idx_d        = clr_idx_q + ADDR_W'(1);
                    if (clr_idx_q == LAST_IDX) begin
                        state_d = ST_RUN;
                        ready_d = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (wr_ok) begin
                        mem_d[WR_ADDR]  = WR_DATA;
                        busy_d[WR_ADDR] = 1'b0;
                    end
                    // Issue is applied after writeback: a newer producer keeps the register pending.
                    if (iss_ok) begin
                        busy_d[ISSUE_ADDR] = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_CLEAR;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        state_q   <= state_d;
        clr_idx_q <= clr_idx_d;
        ready_q   <= ready_d;
        mem_q     <= mem_d;
        busy_q    <= busy_d;
    end

    always_comb begin
        RD1_DATA = '0;
        RD1_BUSY = 1'b0;
        if ((state_q == ST_RUN) && (RD1_ADDR != '0)) begin
            RD1_DATA = mem_q[RD1_ADDR];
            RD1_BUSY = busy_q[RD1_ADDR];
`ifdef REG_FILE_BYPASS_EN
            if (wr_ok && (RD1_ADDR == WR_ADDR)) begin
                RD1_DATA = WR_DATA;
                RD1_BUSY = 1'b0;
            end
`endif
        end
    end

    always_comb begin
        RD2_DATA = '0;
        RD2_BUSY = 1'b0;
        if ((state_q == ST_RUN) && (RD2_ADDR != '0)) begin
            RD2_DATA = mem_q[RD2_ADDR];
            RD2_BUSY = busy_q[RD2_ADDR];
`ifdef REG_FILE_BYPASS_EN
            if (wr_ok && (RD2_ADDR == WR_ADDR)) begin
                RD2_DATA = WR_DATA;
                RD2_BUSY = 1'b0;
            end
`endif
        end
    end

    assign READY = ready_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - directed self-checking bench for reg_file_sb (default and 64x16 builds)
module tb_reg_file_sb;

    logic        CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RESET, WR_EN, ISSUE_EN;
    logic [4:0]  WR_ADDR, ISSUE_ADDR, RD1_ADDR, RD2_ADDR;
    logic [31:0] WR_DATA, RD1_DATA, RD2_DATA;
    logic        RD1_BUSY, RD2_BUSY, READY;

    logic        b_reset, b_wr_en, b_issue_en;
    logic [3:0]  b_wr_addr, b_issue_addr, b_rd1_addr, b_rd2_addr;
    logic [63:0] b_wr_data, b_rd1_data, b_rd2_data;
    logic        b_rd1_busy, b_rd2_busy, b_ready;

    int checks = 0;
    int errors = 0;
    int cnt;
    int nonzero;

    reg_file_sb dut (
        .CLK(CLK), .RESET(RESET), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
        .ISSUE_EN(ISSUE_EN), .ISSUE_ADDR(ISSUE_ADDR), .RD1_ADDR(RD1_ADDR), .RD2_ADDR(RD2_ADDR),
        .RD1_DATA(RD1_DATA), .RD2_DATA(RD2_DATA), .RD1_BUSY(RD1_BUSY), .RD2_BUSY(RD2_BUSY),
        .READY(READY)
    );

    reg_file_sb #(.DATA_W(64), .DEPTH(16)) dut64 (
        .CLK(CLK), .RESET(b_reset), .WR_EN(b_wr_en), .WR_ADDR(b_wr_addr), .WR_DATA(b_wr_data),
        .ISSUE_EN(b_issue_en), .ISSUE_ADDR(b_issue_addr), .RD1_ADDR(b_rd1_addr), .RD2_ADDR(b_rd2_addr),
        .RD1_DATA(b_rd1_data), .RD2_DATA(b_rd2_data), .RD1_BUSY(b_rd1_busy), .RD2_BUSY(b_rd2_busy),
        .READY(b_ready)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (READY !== 1'b1 && n < 100) begin
            step();
            n++;
        end
    endtask

    initial begin
        RESET = 1'b1; WR_EN = 1'b0; ISSUE_EN = 1'b0;
        WR_ADDR = '0; WR_DATA = '0; ISSUE_ADDR = '0; RD1_ADDR = '0; RD2_ADDR = '0;
        b_reset = 1'b1; b_wr_en = 1'b0; b_issue_en = 1'b0;
        b_wr_addr = '0; b_wr_data = '0; b_issue_addr = '0; b_rd1_addr = '0; b_rd2_addr = '0;

        // Reset state and clear duration; writes/issues during CLEAR are ignored
        step();
        RD1_ADDR = 5'd5; RD2_ADDR = 5'd6;
        #1;
        chk("reset_ready", READY, 0);
        chk("reset_rd1_data", RD1_DATA, 0);
        chk("reset_rd2_busy", RD2_BUSY, 0);
        RESET = 1'b0;
        WR_EN = 1'b1; WR_ADDR = 5'd5; WR_DATA = 32'hAAAA_5555;
        ISSUE_EN = 1'b1; ISSUE_ADDR = 5'd6;
        wait_ready(cnt);
        chk("clear_cycles_32", cnt, 32);
        WR_EN = 1'b0; ISSUE_EN = 1'b0;
        #1;
        chk("clear_wr_ignored", RD1_DATA, 0);
        chk("clear_issue_ignored", RD2_BUSY, 0);
        nonzero = 0;
        for (int a = 0; a < 32; a++) begin
            RD1_ADDR = 5'(a);
            #1;
            if (RD1_DATA !== 32'h0 || RD1_BUSY !== 1'b0) nonzero++;
        end
        chk("all_entries_zero", nonzero, 0);

        // Plain write and read on both ports; address 0 discards writes
        WR_EN = 1'b1; WR_ADDR = 5'd7; WR_DATA = 32'hDEAD_BEEF;
        step();
        WR_EN = 1'b0; RD1_ADDR = 5'd7; RD2_ADDR = 5'd7;
        #1;
        chk("wr7_rd1", RD1_DATA, 32'hDEAD_BEEF);
        chk("wr7_rd2", RD2_DATA, 32'hDEAD_BEEF);
        WR_EN = 1'b1; WR_ADDR = 5'd0; WR_DATA = 32'h1234;
        ISSUE_EN = 1'b1; ISSUE_ADDR = 5'd0;
        step();
        WR_EN = 1'b0; ISSUE_EN = 1'b0; RD1_ADDR = 5'd0;
        #1;
        chk("addr0_data", RD1_DATA, 0);
        chk("addr0_busy", RD1_BUSY, 0);

        // Scoreboard: issue sets, writeback clears, simultaneous issue wins
        ISSUE_EN = 1'b1; ISSUE_ADDR = 5'd9;
        step();
        ISSUE_EN = 1'b0; RD1_ADDR = 5'd9;
        #1;
        chk("issue9_busy", RD1_BUSY, 1);
        WR_EN = 1'b1; WR_ADDR = 5'd9; WR_DATA = 32'h55;
        step();
        WR_EN = 1'b0;
        #1;
        chk("wb9_busy", RD1_BUSY, 0);
        chk("wb9_data", RD1_DATA, 32'h55);
        WR_EN = 1'b1; WR_ADDR = 5'd9; WR_DATA = 32'h66;
        ISSUE_EN = 1'b1; ISSUE_ADDR = 5'd9;
        step();
        WR_EN = 1'b0; ISSUE_EN = 1'b0;
        #1;
        chk("wr_iss9_data", RD1_DATA, 32'h66);
        chk("wr_iss9_busy", RD1_BUSY, 1);

        // Same-cycle read of a register being written (with concurrent re-issue)
        WR_EN = 1'b1; WR_ADDR = 5'd3; WR_DATA = 32'h11;
        ISSUE_EN = 1'b1; ISSUE_ADDR = 5'd3;
        step();
        WR_DATA = 32'hA5A5_A5A5; RD2_ADDR = 5'd3;
        #1;
`ifdef REG_FILE_BYPASS_EN
        chk("same_cycle_rd2_data", RD2_DATA, 32'hA5A5_A5A5);
        chk("same_cycle_rd2_busy", RD2_BUSY, 0);
`else
        chk("same_cycle_rd2_data", RD2_DATA, 32'h11);
        chk("same_cycle_rd2_busy", RD2_BUSY, 1);
`endif
        step();
        WR_EN = 1'b0; ISSUE_EN = 1'b0;
        #1;
        chk("after_wr3_data", RD2_DATA, 32'hA5A5_A5A5);
        chk("after_wr3_busy", RD2_BUSY, 1);

        // Mid-operation reset, then reset again in the middle of the clear
        WR_EN = 1'b1; WR_ADDR = 5'd12; WR_DATA = 32'hFF;
        ISSUE_EN = 1'b1; ISSUE_ADDR = 5'd13;
        step();
        WR_EN = 1'b0; ISSUE_EN = 1'b0; RD1_ADDR = 5'd12; RD2_ADDR = 5'd13;
        #1;
        chk("pre_rst_12", RD1_DATA, 32'hFF);
        chk("pre_rst_busy13", RD2_BUSY, 1);
        RESET = 1'b1;
        step();
        chk("midrst_ready", READY, 0);
        chk("midrst_rd1_data", RD1_DATA, 0);
        chk("midrst_rd2_busy", RD2_BUSY, 0);
        RESET = 1'b0;
        for (int i = 0; i < 10; i++) step();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        wait_ready(cnt);
        chk("restart_clear_32", cnt, 32);
        #1;
        chk("post_clear_12", RD1_DATA, 0);
        chk("post_clear_busy13", RD2_BUSY, 0);

        // 64-bit wide, 16-deep build
        step();
        b_reset = 1'b0;
        cnt = 0;
        while (b_ready !== 1'b1 && cnt < 100) begin
            step();
            cnt++;
        end
        chk("w64_clear_16", cnt, 16);
        b_wr_en = 1'b1; b_wr_addr = 4'd15; b_wr_data = 64'hFFFF_FFFF_0000_0001;
        step();
        b_wr_en = 1'b0; b_rd1_addr = 4'd15; b_rd2_addr = 4'd0;
        #1;
        chk("w64_rd15", b_rd1_data, 64'hFFFF_FFFF_0000_0001);
        chk("w64_rd0", b_rd2_data, 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the CPU integer register file.
- 2 asynchronous read ports, 1 synchronous write port, register 0 hardwired to zero.
- Per-register scoreboard (pending-write bits) so the pipeline hazard unit can stall on RAW dependencies.
- Sequential clear engine zeroes the array one entry per cycle after reset, instead of a single-cycle bulk reset.

Parameters:
- DATA_W, 32, register width in bits.
- DEPTH, 32, number of registers; power of 2, at least 2. Localparam ADDR_W = $clog2(DEPTH).

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  reset, synchronous, active-high.
- WR_EN  in  1  writeback enable.
- WR_ADDR  in  ADDR_W  writeback destination.
- WR_DATA  in  DATA_W  writeback data.
- ISSUE_EN  in  1  instruction with a destination issued; marks the destination pending.
- ISSUE_ADDR  in  ADDR_W  destination being issued.
- RD1_ADDR  in  ADDR_W  read port 1 address.
- RD2_ADDR  in  ADDR_W  read port 2 address.
- RD1_DATA  out  DATA_W  read port 1 data.
- RD2_DATA  out  DATA_W  read port 2 data.
- RD1_BUSY  out  1  register at RD1_ADDR has a pending write.
- RD2_BUSY  out  1  register at RD2_ADDR has a pending write.
- READY  out  1  clear sequence complete; writes and issues are accepted.

Behaviour:
- FSM states: CLEAR and RUN.
- RESET=1 at posedge:
  - state <= CLEAR, clear index <= 0.
  - All scoreboard bits <= 0 in the same cycle.
  - READY <= 0.
  - Applies identically mid-operation, including mid-CLEAR (index restarts at 0).
- CLEAR state:
  - Each cycle writes 0 to entry[index], then index++.
  - The cycle that writes entry DEPTH-1 transitions to RUN; READY goes 1 on the next cycle.
  - Duration is exactly DEPTH cycles after RESET deasserts.
  - WR_EN and ISSUE_EN are ignored.
  - RDx_DATA=0 and RDx_BUSY=0 regardless of address.
- RUN state:
  - Write: on posedge with WR_EN=1 and WR_ADDR!=0, entry[WR_ADDR] <= WR_DATA and busy[WR_ADDR] <= 0.
  - Issue: on posedge with ISSUE_EN=1 and ISSUE_ADDR!=0, busy[ISSUE_ADDR] <= 1.
  - Simultaneous WR and ISSUE to the same nonzero address: data is written and busy ends 1 (issue wins; it represents a newer producer).
  - Address 0: writes are discarded, busy[0] is never set, reads return 0 and busy 0.
- Reads: combinational.
  - RDx_DATA = entry[RDx_ADDR]; RDx_BUSY = busy[RDx_ADDR] (after the bypass rule, if enabled).
  - The two read ports are fully independent; identical addresses are legal.
- Outputs immediately after RESET: READY=0, RDx_DATA=0, RDx_BUSY=0.
- No simulation delays on outputs.

Optional Feature:
- Macro REG_FILE_BYPASS_EN.
- Defined:
  - In RUN, if WR_EN=1, WR_ADDR!=0 and RDx_ADDR==WR_ADDR, then RDx_DATA=WR_DATA and RDx_BUSY=0 in the same cycle (write-through forwarding).
  - This applies even when ISSUE to the same address occurs that cycle.
- Undefined:
  - Reads return the old array value until the posedge commits the write.
  - RDx_BUSY reflects busy state before the posedge.

Test Plan:
1. RESET 1 cycle, DEPTH=32 -> READY=0 for exactly 32 cycles, then 1; reading every address returns 0; WR_EN=1 to addr 5 during CLEAR is ignored (addr 5 reads 0 in RUN).
2. RUN: write 0xDEADBEEF to addr 7, read on both ports next cycle -> 0xDEADBEEF; write 0x1234 to addr 0 -> RD1_ADDR=0 reads 0.
3. ISSUE addr 9 -> RD1_BUSY=1 next cycle; WR addr 9 data 0x55 -> busy 0 and data 0x55 next cycle; simultaneous WR+ISSUE addr 9 -> data updated, busy stays 1.
4. Bypass: WR_EN=1, addr 3, 0xA5A5A5A5, RD2_ADDR=3 in the same cycle -> with REG_FILE_BYPASS_EN, RD2_DATA=0xA5A5A5A5 and RD2_BUSY=0 that cycle; without it, the old value.
5. Mid-operation RESET after writing addr 12=0xFF and issuing addr 13 -> READY drops; after the clear, addr 12 reads 0 and busy[13]=0; RESET asserted again mid-CLEAR restarts the full DEPTH-cycle count.
6. DATA_W=64, DEPTH=16 build -> 16-cycle clear; write 0xFFFFFFFF00000001 to addr 15 reads back exactly.
